// File: rtl/snake_food_gen_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared constants and types for the snake food generator:
//   - CELL_SIZE              : default cell size in pixels
//   - GRID_*                 : legal food cell range (x 2..61, y 2..45)
//   - FALLBACK_*             : cell used when every random draw is rejected
//   - LFSR_SEED / LFSR_TAP_* : 16-bit Fibonacci LFSR seed and tap positions
//   - HEAD_*                 : offsets of the display cell encoding of the head
//   - stateT                 : generator FSM states
// Optional feature macro used by the design: FOOD_AVOID_HEAD_EN.
// -----------------------------------------------------------------------------
package snake_pkg;

  localparam int CELL_SIZE = 10;

  localparam logic [5:0] GRID_X_MIN = 6'd2;
  localparam logic [5:0] GRID_X_MAX = 6'd61;
  localparam logic [5:0] GRID_Y_MIN = 6'd2;
  localparam logic [5:0] GRID_Y_MAX = 6'd45;

  localparam logic [5:0] FALLBACK_X     = 6'd32;
  localparam logic [5:0] FALLBACK_X_ALT = 6'd33;
  localparam logic [5:0] FALLBACK_Y     = 6'd24;

  localparam logic [3:0] RETRY_MAX = 4'd15;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Tap positions in the usual 1-based polynomial notation (x^16+x^14+x^13+x^11+1)
  localparam int LFSR_TAP_A = 16;
  localparam int LFSR_TAP_B = 14;
  localparam int LFSR_TAP_C = 13;
  localparam int LFSR_TAP_D = 11;

  // The head arrives in the display's own cell numbering, which is shifted
  // relative to the food grid by (14,3) cells and uses 80 rows per column.
  localparam logic [13:0] HEAD_X_BIAS = 14'd14;
  localparam logic [13:0] HEAD_Y_BIAS = 14'd3;
  localparam logic [13:0] HEAD_ROW    = 14'd80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CHECK = 2'd2,
    LOAD  = 2'd3
  } stateT;

  // Food grid cell -> display cell number used by iHeadCell
  function automatic logic [13:0] headEnc(input logic [5:0] cx, input logic [5:0] cy);
    return ({8'd0, cx} + HEAD_X_BIAS) * HEAD_ROW + HEAD_Y_BIAS + {8'd0, cy};
  endfunction

endpackage

// File: rtl/snake_food_gen_if.sv
// -----------------------------------------------------------------------------
// snake_food_gen_if
// Request/result bundle of the food generator.
//   iReq      : level request for a new food position
//   iHeadCell : snake head in display cell encoding
//   oFoodX/Y  : food position in H_Cont / V_Cont pixel units
//   oValid    : one-cycle pulse when oFoodX/oFoodY update
//   oBusy     : generator is working on a request
// master = requester (game logic), slave = generator.
// -----------------------------------------------------------------------------
interface snake_food_gen_if;
  logic        iReq;
  logic [13:0] iHeadCell;
  logic [9:0]  oFoodX;
  logic [9:0]  oFoodY;
  logic        oValid;
  logic        oBusy;

  modport master (
    output iReq, iHeadCell,
    input  oFoodX, oFoodY, oValid, oBusy
  );

  modport slave (
    input  iReq, iHeadCell,
    output oFoodX, oFoodY, oValid, oBusy
  );
endinterface

// File: rtl/snake_food_gen_lfsr.sv
// -----------------------------------------------------------------------------
// snake_lfsr16
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1,
// shifting towards bit 0 with the feedback entering at bit 15.
//   iCLK   : clock (rising edge)
//   iRST_N : asynchronous active-low reset, loads SEED
//   oLfsr  : current LFSR state
// -----------------------------------------------------------------------------
module snake_lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  output logic [15:0] oLfsr
);

  logic [15:0] lfsrReg;
  logic        feedback;

  // Tap n of the polynomial sits at bit (16-n) for a right-shifting register
  assign feedback = lfsrReg[16-LFSR_TAP_A] ^ lfsrReg[16-LFSR_TAP_B]
                  ^ lfsrReg[16-LFSR_TAP_C] ^ lfsrReg[16-LFSR_TAP_D];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      lfsrReg <= SEED;
    end else begin
      lfsrReg <= {feedback, lfsrReg[15:1]};
    end
  end

  assign oLfsr = lfsrReg;

endmodule

// File: rtl/snake_food_gen.sv
// -----------------------------------------------------------------------------
// snake_food_gen
// Picks a random food cell on request. Candidates come from a free-running
// LFSR; out-of-grid candidates are redrawn up to 15 times, after which a fixed
// fallback cell is used. Result is converted to VGA counter pixel units.
//   iCLK   : clock (rising edge)
//   iRST_N : asynchronous active-low reset
//   bus    : snake_food_gen_if.slave (iReq, iHeadCell, oFoodX, oFoodY,
//            oValid, oBusy)
// Optional feature: define FOOD_AVOID_HEAD_EN to also reject the cell under
// the snake head (and move the fallback one cell right if the head is on it).
// -----------------------------------------------------------------------------
module snake_food_gen
  import snake_pkg::*;
#(
  parameter int H_OFFSET = 144,
  parameter int V_OFFSET = 35,
  parameter int CELL     = CELL_SIZE
) (
  input logic             iCLK,
  input logic             iRST_N,
  snake_food_gen_if.slave bus
);

  localparam logic [9:0] CELL_BITS  = 10'(CELL);
  localparam logic [9:0] FOOD_X_RST = 10'(H_OFFSET + int'(FALLBACK_X) * CELL);
  localparam logic [9:0] FOOD_Y_RST = 10'(V_OFFSET + int'(FALLBACK_Y) * CELL);

  logic [15:0] lfsr;

  stateT       stateReg;
  logic [3:0]  retryReg;
  logic [5:0]  cellXReg;
  logic [5:0]  cellYReg;
  logic [9:0]  foodXReg;
  logic [9:0]  foodYReg;
  logic        validReg;
  logic        busyReg;

  logic        inGrid;
  logic        candOk;
  logic [5:0]  fallbackX;
  logic [9:0]  xTerm [10];
  logic [9:0]  yTerm [10];
  logic [9:0]  scaledX;
  logic [9:0]  scaledY;
  logic [9:0]  foodXNext;
  logic [9:0]  foodYNext;

  snake_lfsr16 #(.SEED(LFSR_SEED)) uLfsr (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .oLfsr  (lfsr)
  );

  // cell * CELL as a sum of shifted copies, one per set bit of CELL
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : gShiftAdd
      assign xTerm[gi] = CELL_BITS[gi] ? ({4'd0, cellXReg} << gi) : 10'd0;
      assign yTerm[gi] = CELL_BITS[gi] ? ({4'd0, cellYReg} << gi) : 10'd0;
    end
  endgenerate

  always_comb begin
    scaledX = 10'd0;
    scaledY = 10'd0;
    for (int i = 0; i < 10; i++) begin
      scaledX = scaledX + xTerm[i];
      scaledY = scaledY + yTerm[i];
    end
  end

  assign foodXNext = 10'(H_OFFSET) + scaledX;
  assign foodYNext = 10'(V_OFFSET) + scaledY;

  assign inGrid = (cellXReg >= GRID_X_MIN) && (cellXReg <= GRID_X_MAX) &&
                  (cellYReg >= GRID_Y_MIN) && (cellYReg <= GRID_Y_MAX);

`ifdef FOOD_AVOID_HEAD_EN
  assign candOk    = inGrid && (headEnc(cellXReg, cellYReg) != bus.iHeadCell);
  assign fallbackX = (bus.iHeadCell == headEnc(FALLBACK_X, FALLBACK_Y)) ?
                     FALLBACK_X_ALT : FALLBACK_X;
`else
  // Head position is not consulted in this build
  logic unusedHead;
  assign unusedHead = ^bus.iHeadCell;
  assign candOk     = inGrid;
  assign fallbackX  = FALLBACK_X;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateReg <= IDLE;
      retryReg <= 4'd0;
      cellXReg <= FALLBACK_X;
      cellYReg <= FALLBACK_Y;
      foodXReg <= FOOD_X_RST;
      foodYReg <= FOOD_Y_RST;
      validReg <= 1'b0;
      busyReg  <= 1'b0;
    end else begin
      validReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (bus.iReq) begin
            stateReg <= DRAW;
            busyReg  <= 1'b1;
          end
        end
        DRAW: begin
          cellXReg <= lfsr[5:0];
          cellYReg <= lfsr[11:6];
          stateReg <= CHECK;
        end
        CHECK: begin
          if (candOk) begin
            stateReg <= LOAD;
          end else if (retryReg == RETRY_MAX) begin
            // Out of retries: give up on randomness, use the fixed cell
            cellXReg <= fallbackX;
            cellYReg <= FALLBACK_Y;
            stateReg <= LOAD;
          end else begin
            retryReg <= retryReg + 4'd1;
            stateReg <= DRAW;
          end
        end
        LOAD: begin
          foodXReg <= foodXNext;
          foodYReg <= foodYNext;
          validReg <= 1'b1;
          retryReg <= 4'd0;
          busyReg  <= 1'b0;
          stateReg <= IDLE;
        end
        default: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oFoodX = foodXReg;
  assign bus.oFoodY = foodYReg;
  assign bus.oValid = validReg;
  assign bus.oBusy  = busyReg;

endmodule

// File: tb/tb_snake_food_gen.sv
// -----------------------------------------------------------------------------
// tb_snake_food_gen
// Randomized bench for snake_food_gen with an in-bench reference model that
// predicts, at each accepted request, which LFSR value will be examined on
// each attempt and hence the final food position and latency.
// Honours FOOD_AVOID_HEAD_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_snake_food_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snake_food_gen_if bus();

  snake_food_gen dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  int nChecks = 0;
  int nFail   = 0;
  bit modelOn = 1'b1;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    nChecks++;
    if (!ok) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    // x^16+x^14+x^13+x^11+1, right shift: taps at bits 0,2,3,5
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic int cellEnc(input int cx, input int cy);
    return (14 + cx) * 80 + 3 + cy;
  endfunction

  // Given the LFSR value in the cycle the request is sampled, work out the
  // edges until the result appears and the resulting pixel position.
  function automatic void plan(input logic [15:0] cur, input int head,
                               output int latency, output int fx, output int fy);
    logic [15:0] l;
    int cx, cy;
    bit ok;
    l = lfsrStep(cur);
    for (int j = 0; j < 16; j++) begin
      cx = int'(l[5:0]);
      cy = int'(l[11:6]);
      ok = (cx >= 2) && (cx <= 61) && (cy >= 2) && (cy <= 45);
`ifdef FOOD_AVOID_HEAD_EN
      if (cellEnc(cx, cy) == head) ok = 1'b0;
`endif
      if (ok) begin
        latency = 3 + 2 * j;
        fx = 144 + cx * 10;
        fy = 35 + cy * 10;
        return;
      end
      l = lfsrStep(lfsrStep(l));
    end
    cx = 32;
`ifdef FOOD_AVOID_HEAD_EN
    if (head == cellEnc(32, 24)) cx = 33;
`endif
    latency = 33;
    fx = 144 + cx * 10;
    fy = 35 + 24 * 10;
  endfunction

  logic [15:0] mLfsr  = 16'hACE1;
  bit          mBusy  = 1'b0;
  int          mCnt   = 0;
  int          pX     = 464;
  int          pY     = 275;
  int          lat    = 0;
  logic        eValid = 1'b0;
  logic        eBusy  = 1'b0;
  int          eX     = 464;
  int          eY     = 275;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mLfsr  = 16'hACE1;
      mBusy  = 1'b0;
      mCnt   = 0;
      eValid = 1'b0;
      eBusy  = 1'b0;
      eX     = 464;
      eY     = 275;
    end else begin
      eValid = 1'b0;
      if (mBusy) begin
        mCnt--;
        if (mCnt == 0) begin
          eX     = pX;
          eY     = pY;
          eValid = 1'b1;
          mBusy  = 1'b0;
        end
      end else if (bus.iReq) begin
        plan(mLfsr, int'(bus.iHeadCell), lat, pX, pY);
        mCnt  = lat;
        mBusy = 1'b1;
      end
      eBusy = mBusy;
      mLfsr = lfsrStep(mLfsr);
    end
  end

  // ---------------- per-cycle compare ----------------
  int cyc       = 0;
  int lastValid = -1;

  always @(negedge clk) begin
    if (!rst_n) lastValid = -1;
    if (modelOn) begin
      cyc++;
      check("oValid", bus.oValid === eValid, bus.oValid, eValid);
      check("oBusy",  bus.oBusy  === eBusy,  bus.oBusy,  eBusy);
      check("oFoodX", int'(bus.oFoodX) == eX, bus.oFoodX, eX);
      check("oFoodY", int'(bus.oFoodY) == eY, bus.oFoodY, eY);
      if (bus.oValid === 1'b1) begin
        check("xRange", ((int'(bus.oFoodX) - 144) % 10 == 0) &&
              (int'(bus.oFoodX) >= 164) && (int'(bus.oFoodX) <= 754), bus.oFoodX, 164);
        check("yRange", ((int'(bus.oFoodY) - 35) % 10 == 0) &&
              (int'(bus.oFoodY) >= 55) && (int'(bus.oFoodY) <= 485), bus.oFoodY, 55);
        if (lastValid >= 0)
          check("validGap", (cyc - lastValid) >= 4, cyc - lastValid, 4);
        lastValid = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int cnt;
  logic [15:0] nextCand;

  initial begin
    bus.iReq      = 1'b0;
    bus.iHeadCell = 14'd0;

    // Reset values
    repeat (3) tick();
    check("rstX",     bus.oFoodX == 10'd464, bus.oFoodX, 464);
    check("rstY",     bus.oFoodY == 10'd275, bus.oFoodY, 275);
    check("rstValid", bus.oValid == 1'b0,    bus.oValid, 0);
    check("rstBusy",  bus.oBusy  == 1'b0,    bus.oBusy,  0);

    // First request sampled on the 10th edge after release: LFSR there is
    // 0xC8AB -> cell (43,34) -> (574,375), result three edges later.
    rst_n = 1'b1;
    repeat (9) tick();
    bus.iReq = 1'b1;
    tick();
    bus.iReq = 1'b0;
    check("firstBusy", bus.oBusy == 1'b1, bus.oBusy, 1);
    repeat (2) tick();
    check("firstNoValidEarly", bus.oValid == 1'b0, bus.oValid, 0);
    tick();
    check("firstValid", bus.oValid == 1'b1, bus.oValid, 1);
    check("firstX", bus.oFoodX == 10'd574, bus.oFoodX, 574);
    check("firstY", bus.oFoodY == 10'd375, bus.oFoodY, 375);
    repeat (40) tick();

    // Request held high for 100 cycles
    bus.iReq = 1'b1;
    repeat (100) tick();
    bus.iReq = 1'b0;
    repeat (40) tick();

    // Reset while in CHECK: no pulse, reset outputs next cycle
    bus.iReq = 1'b1;
    tick();
    bus.iReq = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("abortValid", bus.oValid == 1'b0,    bus.oValid, 0);
    check("abortBusy",  bus.oBusy  == 1'b0,    bus.oBusy,  0);
    check("abortX",     bus.oFoodX == 10'd464, bus.oFoodX, 464);
    check("abortY",     bus.oFoodY == 10'd275, bus.oFoodY, 275);
    rst_n = 1'b1;
    repeat (40) tick();

    // Random traffic, with occasional head placed on the upcoming candidate
    for (int i = 0; i < 45000; i++) begin
      bus.iReq = ($urandom_range(0, 3) != 0);
      tick();
      if ((i % 3000) == 2999) begin
        bus.iReq = 1'b0;
        repeat (40) tick();
        nextCand = lfsrStep(mLfsr);
        bus.iHeadCell = 14'(cellEnc(int'(nextCand[5:0]), int'(nextCand[11:6])));
        bus.iReq = 1'b1;
        tick();
        bus.iReq = 1'b0;
        repeat (40) tick();
        bus.iHeadCell = 14'(($urandom_range(0, 59) + 16) * 80 + $urandom_range(5, 48));
        tick();
      end
    end
    bus.iReq = 1'b0;
    repeat (40) tick();

    // Every draw lands on column 0 -> fallback after the full retry budget
    modelOn = 1'b0;
    bus.iHeadCell = 14'd3707;
    force dut.uLfsr.lfsrReg = 16'h0040;
    tick();
    bus.iReq = 1'b1;
    tick();
    bus.iReq = 1'b0;
    cnt = 1;
    while (bus.oValid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("fallbackLatency", (cnt - 1) == 33, cnt - 1, 33);
`ifdef FOOD_AVOID_HEAD_EN
    check("fallbackX", bus.oFoodX == 10'd474, bus.oFoodX, 474);
`else
    check("fallbackX", bus.oFoodX == 10'd464, bus.oFoodX, 464);
`endif
    check("fallbackY", bus.oFoodY == 10'd275, bus.oFoodY, 275);
    release dut.uLfsr.lfsrReg;
    rst_n = 1'b0;
    tick();
    bus.iHeadCell = 14'd0;
    modelOn = 1'b1;
    tick();
    rst_n = 1'b1;

    // Model back in step after reset
    for (int i = 0; i < 400; i++) begin
      bus.iReq = ($urandom_range(0, 1) != 0);
      tick();
    end
    bus.iReq = 1'b0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/snake_food_gen.md
SNAKE_FOOD_GEN -- requirements
Module: snake_food_gen

Interface
REQ-001 Parameter H_OFFSET, default 144, first active-video H_Cont value (H_SYNC_CYC+H_SYNC_BACK) SHALL be added to the pixel X output.
REQ-002 Parameter V_OFFSET, default 35, first active-video V_Cont value (V_SYNC_CYC+V_SYNC_BACK) SHALL be added to the pixel Y output.
REQ-003 Parameter CELL, default 10, SHALL set the cell size in pixels.
REQ-004 iCLK  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 iRST_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 iReq  in  1  SHALL be the request for a new food position (level, sampled per cycle).
REQ-007 iHeadCell  in  14  SHALL be the snake head in display cell encoding: (X/CELL)*80 + Y/CELL.
REQ-008 oFoodX  out  10  SHALL be the food X in H_Cont pixel units.
REQ-009 oFoodY  out  10  SHALL be the food Y in V_Cont pixel units.
REQ-010 oValid  out  1  SHALL be a one-cycle pulse when oFoodX/oFoodY take a new value.
REQ-011 oBusy  out  1  SHALL be high in every state except IDLE.

Function
REQ-012 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL step every cycle, including when IDLE.
REQ-013 FSM states SHALL be IDLE, DRAW, CHECK, LOAD.
REQ-014 IDLE -> DRAW on iReq=1; iReq in any other state SHALL be ignored, with no queueing.
REQ-015 DRAW SHALL latch candidate cellX=lfsr[5:0] and cellY=lfsr[11:6], then go to CHECK.
REQ-016 CHECK SHALL reject the candidate if cellX<2, cellX>61, cellY<2, or cellY>45.
REQ-017 On reject in CHECK, the FSM SHALL increment the 4-bit retry counter and return to DRAW.
REQ-018 On accept in CHECK, the FSM SHALL go to LOAD.
REQ-019 When the retry counter reaches 15 and CHECK rejects again, the candidate SHALL be forced to fallback cell (32,24) and the FSM SHALL go to LOAD.
REQ-020 LOAD SHALL register oFoodX=H_OFFSET+cellX*CELL and oFoodY=V_OFFSET+cellY*CELL, pulse oValid, clear the retry counter, and return to IDLE.
REQ-021 Minimum latency SHALL be 3 cycles from iReq sampled in IDLE to oValid high; maximum latency SHALL be 33 cycles.
REQ-022 Arithmetic SHALL be unsigned; cellX*CELL SHALL be computed by shift-add; the 10-bit results SHALL never overflow within the ranges of REQ-016.
REQ-023 oFoodX/oFoodY SHALL hold their value between LOAD cycles.

Reset
REQ-024 While iRST_N=0: state=IDLE, LFSR=16'hACE1, retry=0, oValid=0, oBusy=0, oFoodX=464, oFoodY=275 (cell 32,24).
REQ-025 Reset asserted in any state SHALL abort the draw without an oValid pulse.
REQ-026 After reset release, the first iReq SHALL behave as from IDLE.

Configuration
REQ-027 With FOOD_AVOID_HEAD_EN defined, CHECK SHALL additionally reject a candidate whose (14+cellX)*80+(3+cellY) equals iHeadCell.
REQ-028 With FOOD_AVOID_HEAD_EN defined, the fallback cell SHALL become (33,24) when (32,24) equals iHeadCell.
REQ-029 Without FOOD_AVOID_HEAD_EN, iHeadCell SHALL be ignored; the port SHALL remain present.

Structure
REQ-030 Package snake_pkg SHALL hold CELL, the grid bounds (2..61, 2..45), the fallback cell, the LFSR seed and taps, and the FSM state typedef.
REQ-031 The LFSR SHALL be a sub-module snake_lfsr16 (clock, reset, 16-bit state out).

Verification
REQ-032 Reset, then a 1-cycle iReq at cycle 10 -> oBusy high on cycle 11; oValid exactly once; oFoodX-144 and oFoodY-35 are multiples of 10 within 20..610 and 20..450.
REQ-033 iReq held high for 100 cycles -> oValid pulses separated by at least 4 cycles; no pulse while oBusy is high from a prior request.
REQ-034 Force the LFSR so every candidate has cellX=0 -> oValid at cycle 33 with oFoodX=464, oFoodY=275.
REQ-035 FOOD_AVOID_HEAD_EN defined, iHeadCell=3707, forced fallback -> oFoodX=474, oFoodY=275; without the macro -> oFoodX=464.
REQ-036 Assert iRST_N=0 while in CHECK -> no oValid pulse, outputs 464/275, oBusy=0 on the next cycle.
REQ-037 10,000 requests -> no output outside bounds; LFSR never reaches zero.
